banco_registradores: RTL and testbench

BANCO_REGISTRADORES -- requirements
Module: banco_registradores

---
 rtl/ula_pkg.sv | 28 ++
 rtl/registrador_flags.sv | 18 +
 rtl/banco_registradores.sv | 94 +++++++++
 tb/tb_banco_registradores.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared datapath constants: word/register-file geometry, flag-mask bit
// positions and the ALU operation codes used by the control unit.
package ula_pkg;

  localparam int bits_palavra  = 16;
  localparam int num_regs      = 8;
  localparam int bits_endereco = 3;

  // Bit positions of each flag inside atualiza_flags and the packed flag word
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 0;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_NOT = 5'b00101;
  localparam logic [4:0] ALU_SHL = 5'b00110;
  localparam logic [4:0] ALU_SHR = 5'b00111;
  localparam logic [4:0] ALU_INC = 5'b01000;
  localparam logic [4:0] ALU_DEC = 5'b01001;
  localparam logic [4:0] ALU_PASS_A = 5'b01010;
  localparam logic [4:0] ALU_PASS_B = 5'b01011;

endpackage

// File: rtl/registrador_flags.sv
// 4-bit flag register: each bit loads from d only where its mask bit is set.
module registrador_flags (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] mascara,
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= 4'b0000;
    end else begin
      q <= (q & ~mascara) | (d & mascara);
    end
  end

endmodule

// File: rtl/banco_registradores.sv
// General register file with two combinational read ports, write-through
// forwarding on both ports, and the ALU flag register.
module banco_registradores #(
  parameter int bits_palavra  = ula_pkg::bits_palavra,
  parameter int num_regs      = ula_pkg::num_regs,
  parameter int bits_endereco = ula_pkg::bits_endereco
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [bits_endereco-1:0] end_a,
  input  logic [bits_endereco-1:0] end_b,
  output logic [bits_palavra-1:0]  operandoA,
  output logic [bits_palavra-1:0]  operandoB,
  input  logic                     escreve,
  input  logic [bits_endereco-1:0] end_escrita,
  input  logic [bits_palavra-1:0]  dado_escrita,
  input  logic                     Z_in,
  input  logic                     C_in,
  input  logic                     S_in,
  input  logic                     O_in,
  input  logic [3:0]               atualiza_flags,
  output logic                     Z,
  output logic                     C,
  output logic                     S,
  output logic                     O
);

  import ula_pkg::FLAG_Z;
  import ula_pkg::FLAG_C;
  import ula_pkg::FLAG_S;
  import ula_pkg::FLAG_O;

  logic [bits_palavra-1:0] regs [num_regs];

  logic a_valido, b_valido, w_valido;
  logic fwd_a, fwd_b;
  logic [3:0] flags_d, flags_q;

  // Addresses beyond num_regs only exist when num_regs is not a power of two
  assign a_valido = (int'(end_a) < num_regs);
  assign b_valido = (int'(end_b) < num_regs);
  assign w_valido = (int'(end_escrita) < num_regs);

  assign fwd_a = escreve && w_valido && (end_escrita == end_a);
  assign fwd_b = escreve && w_valido && (end_escrita == end_b);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < num_regs; i++) begin
        regs[i] <= '0;
      end
    end else if (escreve && w_valido) begin
      regs[end_escrita] <= dado_escrita;
    end
  end

  // Forwarding stays active during reset: only stored state is cleared
  always_comb begin
    operandoA = '0;
    operandoB = '0;
    if (fwd_a) begin
      operandoA = dado_escrita;
    end else if (a_valido) begin
      operandoA = regs[end_a];
    end
    if (fwd_b) begin
      operandoB = dado_escrita;
    end else if (b_valido) begin
      operandoB = regs[end_b];
    end
  end

  always_comb begin
    flags_d         = 4'b0000;
    flags_d[FLAG_Z] = Z_in;
    flags_d[FLAG_C] = C_in;
    flags_d[FLAG_S] = S_in;
    flags_d[FLAG_O] = O_in;
  end

  registrador_flags u_flags (
    .clock   (clock),
    .reset   (reset),
    .mascara (atualiza_flags),
    .d       (flags_d),
    .q       (flags_q)
  );

  assign Z = flags_q[FLAG_Z];
  assign C = flags_q[FLAG_C];
  assign S = flags_q[FLAG_S];
  assign O = flags_q[FLAG_O];

endmodule

// File: tb/tb_banco_registradores.sv
// Bench for banco_registradores: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_banco_registradores;

  localparam int W  = 16;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clock;
  logic          reset;
  logic [AW-1:0] end_a, end_b, end_escrita;
  logic [W-1:0]  operandoA, operandoB, dado_escrita;
  logic          escreve;
  logic          Z_in, C_in, S_in, O_in;
  logic [3:0]    atualiza_flags;
  logic          Z, C, S, O;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: plain array of register contents plus a flag nibble {Z,C,S,O}
  logic [W-1:0] m_regs [NR];
  logic [3:0]   m_flags;
  logic         model_valid = 1'b0;

  banco_registradores dut (
    .clock          (clock),
    .reset          (reset),
    .end_a          (end_a),
    .end_b          (end_b),
    .operandoA      (operandoA),
    .operandoB      (operandoB),
    .escreve        (escreve),
    .end_escrita    (end_escrita),
    .dado_escrita   (dado_escrita),
    .Z_in           (Z_in),
    .C_in           (C_in),
    .S_in           (S_in),
    .O_in           (O_in),
    .atualiza_flags (atualiza_flags),
    .Z              (Z),
    .C              (C),
    .S              (S),
    .O              (O)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the active edge from the inputs held stable across it
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NR; i++) m_regs[i] <= '0;
      m_flags     <= 4'b0000;
      model_valid <= 1'b1;
    end else begin
      if (escreve) m_regs[end_escrita] <= dado_escrita;
      if (atualiza_flags[3]) m_flags[3] <= Z_in;
      if (atualiza_flags[2]) m_flags[2] <= C_in;
      if (atualiza_flags[1]) m_flags[1] <= S_in;
      if (atualiza_flags[0]) m_flags[0] <= O_in;
    end
  end

  // Compare process: mid-cycle, every cycle once the model is known
  always @(negedge clock) begin
    logic [W-1:0] exp_a, exp_b;
    if (model_valid) begin
      exp_a = (escreve && end_escrita == end_a) ? dado_escrita : m_regs[end_a];
      exp_b = (escreve && end_escrita == end_b) ? dado_escrita : m_regs[end_b];
      chk("model_operandoA", 32'(operandoA), 32'(exp_a));
      chk("model_operandoB", 32'(operandoB), 32'(exp_b));
      chk("model_flags", 32'({Z, C, S, O}), 32'(m_flags));
    end
  end

  // Driver: apply one cycle of inputs just after the active edge
  task automatic drive(input logic rst, input logic we, input logic [AW-1:0] wa,
                       input logic [W-1:0] wd, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rb, input logic [3:0] mask,
                       input logic [3:0] fin);
    @(posedge clock);
    #1;
    reset          = rst;
    escreve        = we;
    end_escrita    = wa;
    dado_escrita   = wd;
    end_a          = ra;
    end_b          = rb;
    atualiza_flags = mask;
    {Z_in, C_in, S_in, O_in} = fin;
    #2;
  endtask

  task automatic idle_read(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    drive(1'b0, 1'b0, 3'd0, 16'h0000, ra, rb, 4'b0000, 4'b0000);
  endtask

  initial begin
    logic [W:0]   sum;
    logic [W-1:0] res;
    logic [3:0]   fin;

    reset = 1'b1; escreve = 1'b0; end_escrita = '0; dado_escrita = '0;
    end_a = '0; end_b = '0; atualiza_flags = '0;
    Z_in = 1'b0; C_in = 1'b0; S_in = 1'b0; O_in = 1'b0;

    // Reset then idle: every address reads zero, flags clear
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 4'b0000, 4'b0000);
    for (int i = 0; i < NR; i++) begin
      idle_read(AW'(i), AW'(NR - 1 - i));
      chk("reset_A", 32'(operandoA), 32'h0000);
      chk("reset_B", 32'(operandoB), 32'h0000);
    end
    chk("reset_flags", 32'({Z, C, S, O}), 32'h0);

    // Write then read
    drive(1'b0, 1'b1, 3'd3, 16'h1234, 3'd0, 3'd0, 4'b0000, 4'b0000);
    idle_read(3'd3, 3'd5);
    chk("wr_R3", 32'(operandoA), 32'h1234);
    chk("wr_R5", 32'(operandoB), 32'h0000);

    // Forwarding on both ports in the same cycle
    drive(1'b0, 1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd2, 4'b0000, 4'b0000);
    chk("fwd_A", 32'(operandoA), 32'hBEEF);
    chk("fwd_B", 32'(operandoB), 32'hBEEF);
    idle_read(3'd2, 3'd3);
    chk("fwd_R2_after", 32'(operandoA), 32'hBEEF);

    // Masked flag update, then hold
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 4'b1010, 4'b1111);
    chk("flags_no_bypass", 32'({Z, C, S, O}), 32'h0);
    idle_read(3'd0, 3'd0);
    chk("flags_masked", 32'({Z, C, S, O}), 32'b1010);
    idle_read(3'd0, 3'd0);
    chk("flags_hold", 32'({Z, C, S, O}), 32'b1010);

    // Reset priority over a write and a full flag update
    drive(1'b1, 1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd3, 4'b1111, 4'b1111);
    chk("rst_fwd_A", 32'(operandoA), 32'hFFFF);
    idle_read(3'd7, 3'd3);
    chk("rst_R7", 32'(operandoA), 32'h0000);
    chk("rst_R3", 32'(operandoB), 32'h0000);
    chk("rst_flags", 32'({Z, C, S, O}), 32'h0);

    // ALU loop: 0x7FFF + 0x0001
    drive(1'b0, 1'b1, 3'd1, 16'h7FFF, 3'd0, 3'd0, 4'b0000, 4'b0000);
    drive(1'b0, 1'b1, 3'd2, 16'h0001, 3'd0, 3'd0, 4'b0000, 4'b0000);
    idle_read(3'd1, 3'd2);
    chk("alu_R1", 32'(operandoA), 32'h7FFF);
    chk("alu_R2", 32'(operandoB), 32'h0001);
    sum = {1'b0, 16'h7FFF} + {1'b0, 16'h0001};
    res = sum[W-1:0];
    fin = {res == 0, sum[W], res[W-1], (~(1'b0 ^ 1'b0)) & (res[W-1] != 1'b0)};
    drive(1'b0, 1'b1, 3'd3, res, 3'd1, 3'd2, 4'b1111, fin);
    idle_read(3'd3, 3'd1);
    chk("alu_R3", 32'(operandoA), 32'h8000);
    chk("alu_flags", 32'({Z, C, S, O}), 32'b0011);

    // Randomized traffic, checked by the compare process every cycle
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, NR - 1)), W'($urandom),
            AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    idle_read(3'd0, 3'd0);

    @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
